// File: rtl/tx_event_scheduler.sv
// tx_event_scheduler: collects board/UI events and serialises them as single bytes
// to the async transmitter, using sticky pending flags and an ordered scan-byte FIFO.
module tx_event_scheduler #(
  parameter int unsigned SCAN_DEPTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              user_turn_done,
  input  logic                              draw,
  input  logic                              resign,
  input  logic                              reset_done,
  input  logic                              offset_done,
  input  logic                              movement_done,
  input  logic [2:0]                        move_dir,
  input  logic                              sending_scan_left,
  input  logic                              sending_scan_right,
  input  logic [4:0]                        pieces,
  input  logic                              new_game,
  input  logic [2:0]                        black_setting,
  input  logic [2:0]                        white_setting,
  input  logic                              tx_busy,
  output logic [7:0]                        tx_data,
  output logic                              tx_start,
  output logic [$clog2(SCAN_DEPTH):0]       scan_level,
  output logic                              scan_overflow,
  output logic                              sched_idle
);

  localparam int unsigned AW = $clog2(SCAN_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned NF = 7;

  // Flag bit positions, also the arbitration order (scan FIFO sits between MOVE and NEWG)
  localparam int unsigned F_TURN   = 0;
  localparam int unsigned F_DRAW   = 1;
  localparam int unsigned F_RESIGN = 2;
  localparam int unsigned F_RESET  = 3;
  localparam int unsigned F_OFFSET = 4;
  localparam int unsigned F_MOVE   = 5;
  localparam int unsigned F_NEWG   = 6;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO} state_t;

  state_t            state, state_n;
  logic [NF-1:0]     flags, flags_n, pulses, clr;
  logic [2:0]        move_dir_q, black_q, white_q;
  logic [7:0]        mem [SCAN_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, wr_ptr_r;
  logic [LW-1:0]     count, count_n, free_slots;
  logic [TW-1:0]     tmo, tmo_n;
  logic [7:0]        arb_byte, tx_data_n;
  logic              arb_pop, any_ready, load, pop, push_l, push_r, drop;
  logic              tx_start_n, idle_n;

  assign pulses = {new_game, movement_done, offset_done, reset_done,
                   resign, draw, user_turn_done};
  assign any_ready = (|flags) || (count != '0);

  // Fixed-priority selection of the next byte to send
  always_comb begin
    arb_byte = 8'h00;
    clr      = '0;
    arb_pop  = 1'b0;
    if (flags[F_TURN]) begin
      arb_byte = 8'h00;
      clr[F_TURN] = 1'b1;
    end else if (flags[F_DRAW]) begin
      arb_byte = 8'h10;
      clr[F_DRAW] = 1'b1;
    end else if (flags[F_RESIGN]) begin
      arb_byte = 8'h20;
      clr[F_RESIGN] = 1'b1;
    end else if (flags[F_RESET]) begin
      arb_byte = 8'h7F;
      clr[F_RESET] = 1'b1;
    end else if (flags[F_OFFSET]) begin
      arb_byte = 8'h79;
      clr[F_OFFSET] = 1'b1;
    end else if (flags[F_MOVE]) begin
      arb_byte = {2'b01, move_dir_q, 3'b000};
      clr[F_MOVE] = 1'b1;
    end else if (count != '0) begin
      arb_byte = mem[rd_ptr];
      arb_pop  = 1'b1;
    end else if (flags[F_NEWG]) begin
      arb_byte = {2'b11, black_q, white_q};
      clr[F_NEWG] = 1'b1;
    end
  end

  // Transmit handshake FSM: load in IDLE, strobe, wait for busy to rise then fall
  always_comb begin
    state_n = state;
    tmo_n   = tmo;
    load    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (any_ready && !tx_busy) begin
          load    = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        tmo_n   = '0;
        state_n = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_busy) begin
          state_n = S_WAIT_LO;
        end else if (tmo == TW'(BUSY_TIMEOUT - 1)) begin
          state_n = S_START;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Flag, FIFO and registered-output next-state values
  always_comb begin
    pop        = load && arb_pop;
    flags_n    = (flags & ~(load ? clr : '0)) | pulses;
    free_slots = LW'(SCAN_DEPTH) - count + LW'(pop);
    push_l     = sending_scan_left && (free_slots >= LW'(1));
    push_r     = sending_scan_right && (free_slots >= (push_l ? LW'(2) : LW'(1)));
    drop       = (sending_scan_left && !push_l) || (sending_scan_right && !push_r);
    wr_ptr_r   = wr_ptr + AW'(push_l);
    wr_ptr_n   = wr_ptr + AW'(push_l) + AW'(push_r);
    rd_ptr_n   = rd_ptr + AW'(pop);
    count_n    = count + LW'(push_l) + LW'(push_r) - LW'(pop);
    tx_data_n  = load ? arb_byte : tx_data;
    tx_start_n = (state_n == S_START);
    idle_n     = (state_n == S_IDLE) && (flags_n == '0) && (count_n == '0);
  end

  // Scan-byte storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_l) mem[wr_ptr]   <= {3'b101, pieces};
    if (push_r) mem[wr_ptr_r] <= {3'b100, pieces};
  end

  // State, flags, payloads and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      tmo           <= '0;
      flags         <= '0;
      move_dir_q    <= '0;
      black_q       <= '0;
      white_q       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      tx_data       <= '0;
      tx_start      <= 1'b0;
      scan_overflow <= 1'b0;
      sched_idle    <= 1'b1;
    end else begin
      state    <= state_n;
      tmo      <= tmo_n;
      flags    <= flags_n;
      if (movement_done) move_dir_q <= move_dir;
      if (new_game) begin
        black_q <= black_setting;
        white_q <= white_setting;
      end
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      tx_data  <= tx_data_n;
      tx_start <= tx_start_n;
      if (drop) scan_overflow <= 1'b1;
      sched_idle <= idle_n;
    end
  end

  assign scan_level = count;

endmodule

// File: tb/tb_tx_event_scheduler.sv
// Bench for tx_event_scheduler: transmitter model, expected-byte scoreboard and directed tests.
module tb_tx_event_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       user_turn_done = 0, draw = 0, resign = 0, reset_done = 0, offset_done = 0;
  logic       movement_done = 0, sending_scan_left = 0, sending_scan_right = 0, new_game = 0;
  logic [2:0] move_dir = 0, black_setting = 0, white_setting = 0;
  logic [4:0] pieces = 0;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [3:0] scan_level;
  logic       scan_overflow;
  logic       sched_idle;

  logic       busy_hold = 0, model_busy = 0, model_en = 1;
  int         busy_len = 10;
  int         busy_cnt = 0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         start_cyc[$];

  assign tx_busy = busy_hold | model_busy;

  tx_event_scheduler #(.SCAN_DEPTH(8), .BUSY_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .user_turn_done(user_turn_done), .draw(draw), .resign(resign),
    .reset_done(reset_done), .offset_done(offset_done),
    .movement_done(movement_done), .move_dir(move_dir),
    .sending_scan_left(sending_scan_left), .sending_scan_right(sending_scan_right),
    .pieces(pieces), .new_game(new_game),
    .black_setting(black_setting), .white_setting(white_setting),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .scan_level(scan_level), .scan_overflow(scan_overflow), .sched_idle(sched_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: goes busy for busy_len cycles after seeing a strobe
  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) model_busy = 1'b0;
    end else if (tx_start && model_en) begin
      model_busy = 1'b1;
      busy_cnt   = busy_len;
    end
  end

  // Monitor: every strobe must match the oldest expected byte
  always @(negedge clk) begin
    if (!rst && tx_start) begin
      start_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte: got tx_data=%02h with no byte expected (cycle %0d)", tx_data, cyc);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          failures++;
          $display("FAIL byte_order: got tx_data=%02h expected %02h (cycle %0d)", tx_data, e, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sched_idle && !tx_busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check({name, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_busy(input string name, input int max_cyc);
    bit ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (tx_busy) begin
        ok = 1;
        break;
      end
    end
    check({name, "_busy"}, 32'(ok), 32'd1);
  endtask

  task automatic clear_pulses();
    user_turn_done = 0; draw = 0; resign = 0; reset_done = 0; offset_done = 0;
    movement_done = 0; sending_scan_left = 0; sending_scan_right = 0; new_game = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int n0;
    bit ok;
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_scan_level", 32'(scan_level), 32'd0);
    check("rst_overflow", 32'(scan_overflow), 32'd0);
    check("rst_idle", 32'(sched_idle), 32'd1);
    rst = 0;
    repeat (2) @(negedge clk);

    // T1: three control events in one cycle, priority order
    busy_len = 10;
    exp_q.push_back(8'h00); exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    n0 = start_cyc.size();
    user_turn_done = 1; draw = 1; resign = 1;
    @(negedge clk); clear_pulses();
    wait_idle("t1", 200);
    check("t1_starts", 32'(start_cyc.size() - n0), 32'd3);

    // T2: scan burst while transmitter held busy; 8 fit, rest dropped
    busy_hold = 1;
    busy_len  = 20;
    pieces    = 5'h15;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 8) begin
        check("t2_level_full", 32'(scan_level), 32'd8);
        check("t2_no_ovf_8", 32'(scan_overflow), 32'd0);
      end
      if (i == 9) check("t2_ovf_9", 32'(scan_overflow), 32'd1);
      sending_scan_left  = (i % 2 == 0);
      sending_scan_right = (i % 2 == 1);
    end
    @(negedge clk); clear_pulses();
    check("t2_level_after", 32'(scan_level), 32'd8);
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 8'hB5 : 8'h95);
    busy_hold = 0;
    wait_idle("t2", 400);
    check("t2_level_empty", 32'(scan_level), 32'd0);

    // T3: two move events coalesce while a byte is in flight; latest dir wins
    busy_len = 10;
    exp_q.push_back(8'h79); exp_q.push_back(8'h68);
    offset_done = 1;
    @(negedge clk); clear_pulses();
    wait_busy("t3", 20);
    movement_done = 1; move_dir = 3'd3;
    @(negedge clk); move_dir = 3'd5;
    @(negedge clk); clear_pulses();
    wait_idle("t3", 200);

    // T4: transmitter never answers -> periodic retry of the same byte
    model_en = 0;
    start_cyc.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h7F);
    reset_done = 1;
    @(negedge clk); clear_pulses();
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (start_cyc.size() >= 4) begin ok = 1; break; end
    end
    check("t4_four_starts", 32'(ok), 32'd1);
    model_en = 1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (start_cyc.size() >= 5) begin ok = 1; break; end
    end
    check("t4_fifth_start", 32'(ok), 32'd1);
    if (start_cyc.size() >= 5)
      for (int i = 1; i < 5; i++)
        check("t4_retry_period", 32'(start_cyc[i] - start_cyc[i-1]), 32'd16);
    wait_idle("t4", 200);

    // T5: new game queued behind two scan bytes pushed in the same cycle
    busy_hold = 1;
    @(negedge clk);
    new_game = 1; black_setting = 3'd1; white_setting = 3'd2;
    sending_scan_left = 1; sending_scan_right = 1; pieces = 5'h0A;
    @(negedge clk); clear_pulses();
    check("t5_level", 32'(scan_level), 32'd2);
    exp_q.push_back(8'hAA); exp_q.push_back(8'h8A); exp_q.push_back(8'hCA);
    busy_hold = 0;
    wait_idle("t5", 300);
    @(negedge clk);
    check("t5_sched_idle", 32'(sched_idle), 32'd1);

    // T6: async reset mid-transfer discards queued bytes
    busy_len = 20;
    pieces   = 5'h03;
    exp_q.push_back(8'hA3);
    for (int i = 0; i < 4; i++) begin
      sending_scan_left  = (i % 2 == 0);
      sending_scan_right = (i % 2 == 1);
      @(negedge clk);
    end
    clear_pulses();
    wait_busy("t6", 20);
    @(negedge clk);
    check("t6_level_before", 32'(scan_level), 32'd3);
    check("t6_byte_sent", 32'(exp_q.size()), 32'd0);
    rst = 1;
    #1;
    check("t6_level_rst", 32'(scan_level), 32'd0);
    check("t6_start_rst", 32'(tx_start), 32'd0);
    check("t6_idle_rst", 32'(sched_idle), 32'd1);
    check("t6_ovf_rst", 32'(scan_overflow), 32'd0);
    check("t6_data_rst", 32'(tx_data), 32'h0);
    repeat (2) @(negedge clk);
    rst = 0;
    n0 = start_cyc.size();
    repeat (80) @(negedge clk);
    check("t6_no_bytes", 32'(start_cyc.size() - n0), 32'd0);
    check("t6_idle_after", 32'(sched_idle), 32'd1);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
